// File: rtl/latealu_issue_ctrl.sv
// Issue controller for the late-stage ALU: small op FIFO, in-order single issue, HI/LO busy window.
// Optional `LATEALU_CTRL_PERF_EN adds perf_stall_cnt (cycles the head waits on HI/LO).
//
// state     | meaning
// IDLE      | HI/LO free; mult/mthi/mtlo at head may issue
// HILO_WAIT | mult in flight; HI/LO ops at head stall, shifts still issue
module latealu_issue_ctrl #(
  parameter int DEPTH    = 2,
  parameter int MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_a1,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a0,
  output logic [31:0] alu_a1,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        hilo_busy
`ifdef LATEALU_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [BW-1:0] BUSY_LOAD = BW'(MULT_LAT - 1);

  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_SRA  = 6'd3;
  localparam logic [5:0] OP_MULT = 6'd4;
  localparam logic [5:0] OP_MTHI = 6'd5;
  localparam logic [5:0] OP_MTLO = 6'd6;

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_HILO_WAIT = 1'b1;

  logic [5:0]    mem_op [DEPTH];
  logic [31:0]   mem_a0 [DEPTH];
  logic [31:0]   mem_a1 [DEPTH];
  logic [4:0]    mem_rd [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [0:0]    state;
  logic [BW-1:0] busy_cnt;
  logic [4:0]    rd_q;

  logic [5:0]    head_op;
  logic [31:0]   head_a0, head_a1;
  logic [4:0]    head_rd;
  logic          nonempty, head_shift, head_hilo, hilo_stall;
  logic          push, pop, issue, mult_issue;

  assign head_op  = mem_op[rd_ptr];
  assign head_a0  = mem_a0[rd_ptr];
  assign head_a1  = mem_a1[rd_ptr];
  assign head_rd  = mem_rd[rd_ptr];

  assign nonempty   = (count != '0);
  assign head_shift = (head_op == OP_SRL) || (head_op == OP_SRA);
  assign head_hilo  = (head_op == OP_MULT) || (head_op == OP_MTHI) || (head_op == OP_MTLO);
  assign hilo_stall = nonempty && head_hilo && (state != S_IDLE);

  // Unknown opcodes are still popped (as bubbles) so they cannot wedge the queue.
  assign pop        = nonempty && !flush && !hilo_stall;
  assign issue      = pop && (head_shift || head_hilo);
  assign mult_issue = issue && (head_op == OP_MULT);
  assign push       = in_valid && in_ready && !flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= in_op;
      mem_a0[wr_ptr] <= in_a0;
      mem_a1[wr_ptr] <= in_a1;
      mem_rd[wr_ptr] <= in_rd;
    end
  end

  // in_ready follows the post-edge occupancy, so a full FIFO refuses pushes even while popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_next;
      in_ready <= (count_next < CW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // HI/LO window is not cancellable: flush leaves the busy timer running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mult_issue) begin
            state    <= S_HILO_WAIT;
            busy_cnt <= BUSY_LOAD;
          end
        end
        S_HILO_WAIT: begin
          if (busy_cnt == '0) state <= S_IDLE;
          else                busy_cnt <= busy_cnt - BW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hilo_busy = (state == S_HILO_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op   <= '0;
      alu_a0   <= '0;
      alu_a1   <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
    end else begin
      alu_op   <= issue ? head_op : 6'd0;
      alu_a0   <= issue ? head_a0 : 32'd0;
      alu_a1   <= issue ? head_a1 : 32'd0;
      rd_q     <= head_rd;
      wb_valid <= (alu_op == OP_SRL) || (alu_op == OP_SRA);
      wb_rd    <= ((alu_op == OP_SRL) || (alu_op == OP_SRA)) ? rd_q : 5'd0;
    end
  end

`ifdef LATEALU_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (hilo_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_latealu_issue_ctrl.sv
// Directed table-driven bench for latealu_issue_ctrl, plus reset-mid-op and MULT_LAT=1 sequences.
module tb_latealu_issue_ctrl;

  localparam logic [5:0] SRL = 6'd2, SRA = 6'd3, MUL = 6'd4, MTHI = 6'd5, MTLO = 6'd6, BAD = 6'h3F;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush;
  logic [5:0]  in_op;
  logic [31:0] in_a0, in_a1;
  logic [4:0]  in_rd;
  logic        in_ready, wb_valid, hilo_busy;
  logic [5:0]  alu_op;
  logic [31:0] alu_a0, alu_a1;
  logic [4:0]  wb_rd;
  logic        in_ready2, wb_valid2, hilo_busy2;
  logic [5:0]  alu_op2;
  logic [31:0] alu_a02, alu_a12;
  logic [4:0]  wb_rd2;
`ifdef LATEALU_CTRL_PERF_EN
  logic [31:0] perf, perf2;
`endif

  always #5 clk = ~clk;

  latealu_issue_ctrl #(.DEPTH(2), .MULT_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a0(in_a0), .in_a1(in_a1), .in_rd(in_rd), .flush(flush), .alu_op(alu_op),
    .alu_a0(alu_a0), .alu_a1(alu_a1), .wb_valid(wb_valid), .wb_rd(wb_rd),
`ifdef LATEALU_CTRL_PERF_EN
    .perf_stall_cnt(perf),
`endif
    .hilo_busy(hilo_busy)
  );

  latealu_issue_ctrl #(.DEPTH(2), .MULT_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
    .in_a0(in_a0), .in_a1(in_a1), .in_rd(in_rd), .flush(flush), .alu_op(alu_op2),
    .alu_a0(alu_a02), .alu_a1(alu_a12), .wb_valid(wb_valid2), .wb_rd(wb_rd2),
`ifdef LATEALU_CTRL_PERF_EN
    .perf_stall_cnt(perf2),
`endif
    .hilo_busy(hilo_busy2)
  );

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] a0, a1;
    logic [4:0]  rd;
    logic        fl;
    logic        e_rdy;
    logic [5:0]  e_op;
    logic [31:0] e_a0, e_a1;
    logic        e_wb;
    logic [4:0]  e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;
  int   n_cmp = 0, n_err = 0;

  task automatic add(input logic v, input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [4:0] rd, input logic fl, input logic e_rdy, input logic [5:0] e_op,
                     input logic [31:0] e_a0, input logic [31:0] e_a1, input logic e_wb,
                     input logic [4:0] e_rd, input logic e_busy);
    tv[nv] = '{v, op, a0, a1, rd, fl, e_rdy, e_op, e_a0, e_a1, e_wb, e_rd, e_busy};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [4:0] rd, input logic fl);
    in_valid = v; in_op = op; in_a0 = a0; in_a1 = a1; in_rd = rd; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  v  op    a0            a1      rd  fl  rdy eop   ea0           ea1     wb  erd busy
    add(1, SRL,  32'h8000_0000, 32'd4, 5,  0,  1,  0,    0,            0,      0,  0,  0); // 0
    add(0, 0,    0,            0,      0,  0,  1,  SRL,  32'h8000_0000, 32'd4, 0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      1,  5,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, MUL,  32'd3,        32'd5,  0,  0,  1,  0,    0,            0,      0,  0,  0); // 4
    add(1, MTHI, 32'h11,       0,      0,  0,  1,  MUL,  32'd3,        32'd5,  0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  MTHI, 32'h11,       0,      0,  0,  0); // 10
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, MUL,  32'd7,        32'd9,  0,  0,  1,  0,    0,            0,      0,  0,  0); // 12
    add(1, SRA,  32'hF000_0000, 32'd8, 3,  0,  1,  MUL,  32'd7,        32'd9,  0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  SRA,  32'hF000_0000, 32'd8, 0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      1,  3,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, MUL,  32'd1,        32'd1,  0,  0,  1,  0,    0,            0,      0,  0,  0); // 18
    add(1, MTHI, 32'h22,       0,      0,  0,  1,  MUL,  32'd1,        32'd1,  0,  0,  1);
    add(1, MTLO, 32'h33,       0,      0,  0,  0,  0,    0,            0,      0,  0,  1);
    add(1, MTLO, 32'h44,       0,      0,  0,  0,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  0,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  0,  0,    0,            0,      0,  0,  0);
    add(1, SRL,  32'h55,       0,      9,  0,  1,  MTHI, 32'h22,       0,      0,  0,  0); // 24
    add(0, 0,    0,            0,      0,  0,  1,  MTLO, 32'h33,       0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, BAD,  32'hDEAD,     0,      4,  0,  1,  0,    0,            0,      0,  0,  0); // 28
    add(1, SRL,  32'h77,       32'd1,  7,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  SRL,  32'h77,       32'd1,  0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      1,  7,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, MUL,  32'd2,        32'd2,  0,  0,  1,  0,    0,            0,      0,  0,  0); // 33
    add(1, MTHI, 32'hAA,       0,      0,  0,  1,  MUL,  32'd2,        32'd2,  0,  0,  1);
    add(1, MTLO, 32'hBB,       0,      0,  0,  0,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  1,  1,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  1);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, SRL,  32'd1,        32'd1,  12, 0,  1,  0,    0,            0,      0,  0,  0); // 41
    add(0, 0,    0,            0,      0,  0,  1,  SRL,  32'd1,        32'd1,  0,  0,  0);
    add(1, MTHI, 32'hCC,       0,      0,  1,  1,  0,    0,            0,      1,  12, 0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(1, SRL,  32'd3,        32'd3,  1,  0,  1,  0,    0,            0,      0,  0,  0); // 46
    add(0, 0,    0,            0,      0,  1,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);
    add(0, 0,    0,            0,      0,  0,  1,  0,    0,            0,      0,  0,  0);

    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset alu_op", {26'd0, alu_op}, 32'd0);
    chk("reset alu_a0", alu_a0, 32'd0);
    chk("reset alu_a1", alu_a1, 32'd0);
    chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("reset hilo_busy", {31'd0, hilo_busy}, 32'd0);

    for (int i = 0; i < nv; i++) begin
      drive(tv[i].v, tv[i].op, tv[i].a0, tv[i].a1, tv[i].rd, tv[i].fl);
      step();
      chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].e_rdy});
      chk($sformatf("row%0d alu_op", i), {26'd0, alu_op}, {26'd0, tv[i].e_op});
      if (tv[i].e_op != 6'd0) begin
        chk($sformatf("row%0d alu_a0", i), alu_a0, tv[i].e_a0);
        chk($sformatf("row%0d alu_a1", i), alu_a1, tv[i].e_a1);
      end
      chk($sformatf("row%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, tv[i].e_wb});
      if (tv[i].e_wb) chk($sformatf("row%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, tv[i].e_rd});
      chk($sformatf("row%0d hilo_busy", i), {31'd0, hilo_busy}, {31'd0, tv[i].e_busy});
`ifdef LATEALU_CTRL_PERF_EN
      if (i == 27 || i == 32) chk($sformatf("row%0d perf_stall_cnt", i), perf, 32'd8);
`endif
    end

    // reset in the middle of a HI/LO window with an op still queued
    drive(1, MUL, 32'd9, 32'd9, 0, 0);
    step();
    drive(1, MTHI, 32'h66, 0, 0, 0);
    step();
    chk("rstseq busy before", {31'd0, hilo_busy}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstseq in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstseq alu_op", {26'd0, alu_op}, 32'd0);
    chk("rstseq busy", {31'd0, hilo_busy}, 32'd0);
    chk("rstseq wb_valid", {31'd0, wb_valid}, 32'd0);
    step();
    chk("rstseq idle1 alu_op", {26'd0, alu_op}, 32'd0);
    chk("rstseq idle1 busy", {31'd0, hilo_busy}, 32'd0);
    step();
    chk("rstseq idle2 alu_op", {26'd0, alu_op}, 32'd0);

    // MULT_LAT=1 instance: busy exactly one cycle, mthi follows one cycle after it drops
    drive(1, MUL, 32'd4, 32'd4, 0, 0);
    step();
    drive(1, MTHI, 32'h5, 0, 0, 0);
    step();
    chk("lat1 mult alu_op", {26'd0, alu_op2}, {26'd0, MUL});
    chk("lat1 busy high", {31'd0, hilo_busy2}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("lat1 busy low", {31'd0, hilo_busy2}, 32'd0);
    chk("lat1 stall alu_op", {26'd0, alu_op2}, 32'd0);
    step();
    chk("lat1 mthi alu_op", {26'd0, alu_op2}, {26'd0, MTHI});
    chk("lat1 mthi alu_a0", alu_a02, 32'h5);
    chk("lat1 mthi busy", {31'd0, hilo_busy2}, 32'd0);
    step();
    chk("lat1 after alu_op", {26'd0, alu_op2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
